// File: rtl/seg7_pkg.sv
// Shared widths, segment patterns and the digit-to-segment decoder
// for the scanned BCD seconds display.
package seg7_pkg;

    localparam int BCD_W = 4;
    localparam int SEG_W = 7;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [SEG_W-1:0] SEG_0     = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    function automatic logic [SEG_W-1:0] seg7_decode(
        input logic [BCD_W-1:0] d
    );
        logic [SEG_W-1:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One cascadable BCD digit: clear/load/up/down with carry or borrow out.
// Ports: clk, reset, clear, load, load_digit, step, up, carry_in -> digit, carry_out.
module bcd_digit_counter
    import seg7_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_digit,
    input  logic             step,
    input  logic             up,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    logic [BCD_W-1:0] r_digit;
    logic             w_at_edge;
    logic             w_adv;

    // At 9 going up or 0 going down this digit rolls and passes
    // the carry/borrow on within the same clock.
    assign w_at_edge = up ? (r_digit == 4'd9) : (r_digit == 4'd0);
    assign w_adv     = step & carry_in;
    assign carry_out = w_adv & w_at_edge;
    assign digit     = r_digit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digit <= '0;
        end else if (clear) begin
            r_digit <= '0;
        end else if (load) begin
            r_digit <= (load_digit > 4'd9) ? 4'd0 : load_digit;
        end else if (w_adv) begin
            if (up)
                r_digit <= w_at_edge ? 4'd0 : r_digit + 4'd1;
            else
                r_digit <= w_at_edge ? 4'd9 : r_digit - 4'd1;
        end
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// Multi-digit BCD up/down seconds counter with a time-multiplexed 7-seg output.
// Ports: clk, reset, en, up, clear, load, load_val -> bcd, tick, wrap, digit_sel, segments.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int MAX_COUNT  = 10_000_000,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_COUNT = 10_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        up,
    input  logic                        clear,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
    output logic [BCD_W*NUM_DIGITS-1:0] bcd,
    output logic                        tick,
    output logic                        wrap,
    output logic [NUM_DIGITS-1:0]       digit_sel,
    output logic [SEG_W-1:0]            segments
);

    localparam int PRE_W  = (MAX_COUNT > 0) ? $clog2(MAX_COUNT + 1) : 1;
    localparam int SCAN_W = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(MAX_COUNT);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_COUNT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [PRE_W-1:0]            r_pre;
    logic                        r_tick;
    logic                        r_wrap;
    logic [SCAN_W-1:0]           r_scan;
    logic [IDX_W-1:0]            r_idx;
    logic [NUM_DIGITS-1:0]       r_sel;

    logic                        w_term;
    logic [NUM_DIGITS:0]         w_carry;
    logic [BCD_W*NUM_DIGITS-1:0] w_bcd;
    logic [IDX_W-1:0]            w_idx_next;
    logic [BCD_W-1:0]            w_sel_digit;

    assign w_term = en & (r_pre == PRE_MAX);

    // Prescaler: clear and load both restart the interval.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pre <= '0;
        end else if (clear || load) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_term ? '0 : r_pre + PRE_W'(1);
        end
    end

    // Digit 0 always sees carry_in=1; a step ripples up the chain.
    assign w_carry[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_counter u_digit (
                .clk        (clk),
                .reset      (reset),
                .clear      (clear),
                .load       (load),
                .load_digit (load_val[gi*BCD_W +: BCD_W]),
                .step       (w_term),
                .up         (up),
                .carry_in   (w_carry[gi]),
                .digit      (w_bcd[gi*BCD_W +: BCD_W]),
                .carry_out  (w_carry[gi+1])
            );
        end
    endgenerate

    // Carry out of the top digit only occurs on a full wrap-around.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (clear || load) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_term;
            r_wrap <= w_carry[NUM_DIGITS];
        end
    end

    assign w_idx_next = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);

    // Scan runs free of en/clear/load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_sel  <= NUM_DIGITS'(1);
        end else if (r_scan == SCAN_LAST) begin
            r_scan <= '0;
            r_idx  <= w_idx_next;
            r_sel  <= NUM_DIGITS'(1) << w_idx_next;
        end else begin
            r_scan <= r_scan + SCAN_W'(1);
        end
    end

    always_comb begin
        w_sel_digit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i))
                w_sel_digit = w_bcd[i*BCD_W +: BCD_W];
        end
    end

    assign bcd       = w_bcd;
    assign tick      = r_tick;
    assign wrap      = r_wrap;
    assign digit_sel = r_sel;
    assign segments  = seg7_decode(w_sel_digit);

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench for seg7_scan_counter at MAX_COUNT=3, NUM_DIGITS=2,
// SCAN_COUNT=2; an integer model predicts every cycle.
module tb_seg7_scan_counter;

    localparam int MC = 3;
    localparam int ND = 2;
    localparam int SC = 2;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    logic       clk = 1'b0;
    logic       reset, en, up, clear, load;
    logic [7:0] load_val;
    logic [7:0] bcd;
    logic       tick, wrap;
    logic [1:0] digit_sel;
    logic [6:0] segments;

    seg7_scan_counter #(
        .MAX_COUNT  (MC),
        .NUM_DIGITS (ND),
        .SCAN_COUNT (SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up        (up),
        .clear     (clear),
        .load      (load),
        .load_val  (load_val),
        .bcd       (bcd),
        .tick      (tick),
        .wrap      (wrap),
        .digit_sel (digit_sel),
        .segments  (segments)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bcd;
        logic       tick;
        logic       wrap;
        logic [1:0] sel;
        logic [6:0] seg;
    } exp_t;

    exp_t sb [$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_val = 0, m_pre = 0, m_st = 0, m_idx = 0;
    bit m_tick = 0, m_wrap = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int sanit(input logic [7:0] lv);
        int hi, lo;
        hi = (lv[7:4] > 4'd9) ? 0 : int'(lv[7:4]);
        lo = (lv[3:0] > 4'd9) ? 0 : int'(lv[3:0]);
        return hi * 10 + lo;
    endfunction

    task automatic cyc();
        exp_t e;
        if (reset) begin
            m_val = 0; m_pre = 0; m_st = 0; m_idx = 0;
            m_tick = 0; m_wrap = 0;
        end else begin
            if (m_st == SC - 1) begin
                m_st  = 0;
                m_idx = (m_idx + 1) % ND;
            end else begin
                m_st++;
            end
            m_tick = 0;
            m_wrap = 0;
            if (clear) begin
                m_val = 0; m_pre = 0;
            end else if (load) begin
                m_val = sanit(load_val); m_pre = 0;
            end else if (en) begin
                if (m_pre == MC) begin
                    m_pre  = 0;
                    m_tick = 1;
                    if (up) begin
                        m_wrap = (m_val == 99);
                        m_val  = (m_val + 1) % 100;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val + 99) % 100;
                    end
                end else begin
                    m_pre++;
                end
            end
        end
        e.bcd  = bcd8(m_val);
        e.tick = m_tick;
        e.wrap = m_wrap;
        e.sel  = 2'(1 << m_idx);
        e.seg  = SEG_TAB[(m_idx == 0) ? (m_val % 10) : (m_val / 10)];
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_bcd",  32'(bcd),       32'(e.bcd));
        chk("sb_tick", 32'(tick),      32'(e.tick));
        chk("sb_wrap", 32'(wrap),      32'(e.wrap));
        chk("sb_sel",  32'(digit_sel), 32'(e.sel));
        chk("sb_seg",  32'(segments),  32'(e.seg));
    endtask

    task automatic run_to_tick(input int maxc, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!m_tick && n < maxc);
        chk("tick_seen", 32'(tick), 32'(1));
    endtask

    task automatic do_load(input logic [7:0] v);
        load     = 1'b1;
        load_val = v;
        cyc();
        load     = 1'b0;
    endtask

    initial begin
        int n;
        int ticks;
        reset = 1'b1; en = 1'b0; up = 1'b1;
        clear = 1'b0; load = 1'b0; load_val = '0;
        cyc();
        cyc();
        chk("rst_bcd",  32'(bcd),       32'(0));
        chk("rst_tick", 32'(tick),      32'(0));
        chk("rst_sel",  32'(digit_sel), 32'(1));
        chk("rst_seg",  32'(segments),  32'h3F);
        reset = 1'b0;

        en = 1'b1; up = 1'b1;
        ticks = 0;
        repeat (40) begin
            cyc();
            ticks += int'(tick);
        end
        chk("t1_ticks", 32'(ticks), 32'(10));
        chk("t1_bcd",   32'(bcd),   32'h10);

        do_load(8'h99);
        run_to_tick(10, n);
        chk("t2_bcd",  32'(bcd),  32'h00);
        chk("t2_wrap", 32'(wrap), 32'(1));
        cyc();
        chk("t2_wrap_off", 32'(wrap), 32'(0));

        up = 1'b0;
        do_load(8'h00);
        run_to_tick(10, n);
        chk("t3_bcd",  32'(bcd),  32'h99);
        chk("t3_wrap", 32'(wrap), 32'(1));
        run_to_tick(10, n);
        chk("t3_bcd2",  32'(bcd),  32'h98);
        chk("t3_wrap2", 32'(wrap), 32'(0));

        cyc();
        cyc();
        en = 1'b0;
        repeat (10) cyc();
        chk("t4_hold", 32'(bcd), 32'h98);
        en = 1'b1;
        run_to_tick(10, n);
        chk("t4_lat", 32'(n),   32'(2));
        chk("t4_bcd", 32'(bcd), 32'h97);

        n = 0;
        while (m_pre != MC && n < 10) begin
            cyc();
            n++;
        end
        do_load(8'h42);
        chk("t5_ld_bcd",  32'(bcd),  32'h42);
        chk("t5_ld_tick", 32'(tick), 32'(0));
        en = 1'b0;
        do_load(8'hA5);
        chk("t5_sanit", 32'(bcd), 32'h05);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t5_clear", 32'(bcd), 32'h00);

        do_load(8'h42);
        repeat (8) begin
            cyc();
            if (digit_sel == 2'b01)
                chk("t6_seg_lo", 32'(segments), 32'h5B);
            else
                chk("t6_seg_hi", 32'(segments), 32'h66);
        end
        en = 1'b1; up = 1'b1;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rst_bcd", 32'(bcd),       32'(0));
        chk("t6_rst_sel", 32'(digit_sel), 32'(1));
        chk("t6_rst_seg", 32'(segments),  32'h3F);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
